// File: rtl/nanorv32_regfile_mp.sv
// NANORV32 register file: two combinational read ports, two write ports, pending-write
// scoreboard and a clear sequencer. Optional same-cycle forwarding under NANORV32_RF_BYPASS_EN.
module nanorv32_regfile_mp #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sel_porta,
  input  logic [ADDR_W-1:0] sel_portb,
  output logic [DATA_W-1:0] porta,
  output logic [DATA_W-1:0] portb,
  input  logic [ADDR_W-1:0] sel_rd0,
  input  logic [DATA_W-1:0] rd0,
  input  logic              write_rd0,
  input  logic [ADDR_W-1:0] sel_rd1,
  input  logic [DATA_W-1:0] rd1,
  input  logic              write_rd1,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_set_sel,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              clear_req,
  output logic              init_done
);

  localparam logic [ADDR_W:0] NREG_W = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_W = NREG_W - 1'b1;

  // Handshake-free: decode/writeback strobes act in the cycle they are high, and only
  // while init_done = 1; nothing is held off or acknowledged.
  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic                  ready;
  logic                  wr0_ok, wr1_ok, set_ok;
  logic [NUM_REGS-1:0]   w0_vec, w1_vec, set_vec, zero_vec;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  // Register exists and is writable/readable (not the hardwired zero register).
  function automatic logic usable(input logic [ADDR_W-1:0] sel);
    logic zero_hit;
    zero_hit = (ZERO_REG != 0) && (sel == '0);
    return ({1'b0, sel} < NREG_W) && !zero_hit;
  endfunction

  assign wr0_ok = ready && write_rd0 && usable(sel_rd0);
  assign wr1_ok = ready && write_rd1 && usable(sel_rd1);
  assign set_ok = ready && busy_set  && usable(busy_set_sel);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_W) state_d = ST_READY;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    w0_vec   = '0;
    w1_vec   = '0;
    set_vec  = '0;
    zero_vec = '0;
    if (wr0_ok) w0_vec[sel_rd0]       = 1'b1;
    if (wr1_ok) w1_vec[sel_rd1]       = 1'b1;
    if (set_ok) set_vec[busy_set_sel] = 1'b1;
    if (!ready && (cnt_q < NREG_W)) zero_vec[cnt_q[ADDR_W-1:0]] = 1'b1;
    // Set after clear: a new producer claims the register in the same cycle.
    busy_d = (busy_q & ~(w0_vec | w1_vec)) | set_vec;
    if (!ready || clear_req) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset; the INIT sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (zero_vec[i])    regs_q[i] <= '0;
      else if (w1_vec[i]) regs_q[i] <= rd1;
      else if (w0_vec[i]) regs_q[i] <= rd0;
    end
  end

  function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = '0;
    if (ready && usable(sel)) v = regs_q[sel];
`ifdef NANORV32_RF_BYPASS_EN
    if (wr1_ok && (sel_rd1 == sel))      v = rd1;
    else if (wr0_ok && (sel_rd0 == sel)) v = rd0;
`endif
    return v;
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] sel);
    logic b;
    b = ready && usable(sel) && busy_q[sel];
`ifdef NANORV32_RF_BYPASS_EN
    if (((wr0_ok && (sel_rd0 == sel)) || (wr1_ok && (sel_rd1 == sel))) &&
        !(set_ok && (busy_set_sel == sel)))
      b = 1'b0;
`endif
    return b;
  endfunction

  always_comb begin
    porta  = read_data(sel_porta);
    portb  = read_data(sel_portb);
    busy_a = read_busy(sel_porta);
    busy_b = read_busy(sel_portb);
  end

endmodule

// File: tb/tb_nanorv32_regfile_mp.sv
// Directed bench for nanorv32_regfile_mp (default parameters); expectations adapt to
// NANORV32_RF_BYPASS_EN when that macro is defined for both files.
module tb_nanorv32_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [4:0]  sel_porta, sel_portb, sel_rd0, sel_rd1, busy_set_sel;
  logic [31:0] porta, portb, rd0, rd1;
  logic        write_rd0, write_rd1, busy_set, busy_a, busy_b, clear_req, init_done;

  logic [31:0] exp_q[$];
  int          total;
  int          bad;

  nanorv32_regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .sel_porta(sel_porta), .sel_portb(sel_portb), .porta(porta), .portb(portb),
    .sel_rd0(sel_rd0), .rd0(rd0), .write_rd0(write_rd0),
    .sel_rd1(sel_rd1), .rd1(rd1), .write_rd1(write_rd1),
    .busy_set(busy_set), .busy_set_sel(busy_set_sel),
    .busy_a(busy_a), .busy_b(busy_b),
    .clear_req(clear_req), .init_done(init_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NANORV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_rd0 = 1'b0;
    write_rd1 = 1'b0;
    busy_set  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard compare: pops the oldest expected value
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic init_window(input string tag, input logic [4:0] rd_sel);
    sel_porta = rd_sel;
    for (int i = 0; i < 32; i++) begin
      expect_val(32'd0);
      #1 check({tag, "_init_done_low"}, {31'd0, init_done});
      if (i == 0) begin
        expect_val(32'd0);
        check({tag, "_porta_in_init"}, porta);
      end
      tick();
    end
    expect_val(32'd1);
    #1 check({tag, "_init_done_high"}, {31'd0, init_done});
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    sel_porta = '0; sel_portb = '0; sel_rd0 = '0; sel_rd1 = '0; busy_set_sel = '0;
    rd0 = '0; rd1 = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    init_window("reset", 5'd1);

    for (int i = 1; i < 32; i++) begin
      sel_porta = 5'(i);
      sel_portb = 5'(31 - i + 1);
      expect_val(32'd0);
      expect_val(32'd0);
      #1 check("post_init_porta", porta);
      check("post_init_portb", portb);
    end

    // x5 write and its visibility timing
    sel_porta = 5'd5; sel_rd0 = 5'd5; rd0 = 32'h1234_5678; write_rd0 = 1'b1;
    expect_val(BYP ? 32'h1234_5678 : 32'd0);
    #1 check("x5_same_cycle", porta);
    tick();
    idle();
    expect_val(32'h1234_5678);
    #1 check("x5_next_cycle", porta);

    // x0 is hardwired
    sel_porta = 5'd0; sel_rd0 = 5'd0; rd0 = 32'hFFFF_FFFF; write_rd0 = 1'b1;
    expect_val(32'd0);
    #1 check("x0_same_cycle", porta);
    tick();
    idle();
    expect_val(32'd0);
    #1 check("x0_after", porta);

    // Dual write to x7: port 1 wins
    sel_porta = 5'd7; sel_portb = 5'd7;
    sel_rd0 = 5'd7; rd0 = 32'hA; write_rd0 = 1'b1;
    sel_rd1 = 5'd7; rd1 = 32'hB; write_rd1 = 1'b1;
    expect_val(BYP ? 32'hB : 32'd0);
    #1 check("x7_same_cycle", porta);
    tick();
    idle();
    expect_val(32'hB);
    expect_val(32'hB);
    #1 check("x7_porta", porta);
    check("x7_portb", portb);

    // Scoreboard on x9
    sel_porta = 5'd9; sel_portb = 5'd9; busy_set = 1'b1; busy_set_sel = 5'd9;
    expect_val(32'd0);
    #1 check("busy9_before_set", {31'd0, busy_a});
    tick();
    idle();
    expect_val(32'd1);
    expect_val(32'd1);
    #1 check("busy9_set_a", {31'd0, busy_a});
    check("busy9_set_b", {31'd0, busy_b});
    sel_rd1 = 5'd9; rd1 = 32'h55; write_rd1 = 1'b1;
    expect_val(BYP ? 32'd0 : 32'd1);
    #1 check("busy9_clear_same_cycle", {31'd0, busy_a});
    tick();
    idle();
    expect_val(32'd0);
    expect_val(32'h55);
    #1 check("busy9_cleared", {31'd0, busy_a});
    check("x9_value", porta);
    busy_set = 1'b1; busy_set_sel = 5'd9;
    tick();
    sel_rd0 = 5'd9; rd0 = 32'h66; write_rd0 = 1'b1;
    expect_val(32'd1);
    #1 check("busy9_set_and_write_same_cycle", {31'd0, busy_a});
    tick();
    idle();
    expect_val(32'd1);
    expect_val(32'h66);
    #1 check("busy9_set_wins", {31'd0, busy_a});
    check("x9_value2", porta);

    // busy_set on x0 never sticks
    sel_porta = 5'd0; busy_set = 1'b1; busy_set_sel = 5'd0;
    tick();
    idle();
    expect_val(32'd0);
    #1 check("busy0_never", {31'd0, busy_a});

    // Clear sequence: x3 and busy x12 wiped, INIT writes ignored, clear_req in INIT ignored
    sel_rd0 = 5'd3; rd0 = 32'h77; write_rd0 = 1'b1; busy_set = 1'b1; busy_set_sel = 5'd12;
    tick();
    idle();
    sel_porta = 5'd3; sel_portb = 5'd12;
    expect_val(32'h77);
    expect_val(32'd1);
    #1 check("x3_before_clear", porta);
    check("busy12_before_clear", {31'd0, busy_b});
    clear_req = 1'b1;
    expect_val(32'd1);
    #1 check("clear_req_cycle_ready", {31'd0, init_done});
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_val(32'd0);
      #1 check("clear_init_done_low", {31'd0, init_done});
      if (i == 0) begin
        expect_val(32'd0);
        check("clear_porta_in_init", porta);
      end
      if (i == 5) clear_req = 1'b1;
      if (i == 20) begin
        sel_rd0 = 5'd3; rd0 = 32'h99; write_rd0 = 1'b1;
      end
      tick();
      idle();
    end
    expect_val(32'd1);
    expect_val(32'd0);
    expect_val(32'd0);
    #1 check("clear_init_done_high", {31'd0, init_done});
    check("x3_after_clear", porta);
    check("busy12_after_clear", {31'd0, busy_b});

    // Reset in the middle of INIT restarts the full sweep
    sel_rd0 = 5'd6; rd0 = 32'h44; write_rd0 = 1'b1;
    tick();
    idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    init_window("midreset", 5'd6);
    sel_porta = 5'd6;
    expect_val(32'd0);
    #1 check("x6_after_restart", porta);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL leftover_expectations: observed %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_regfile_mp.md
Name: nanorv32_regfile_mp

Overview:
- Parametrised next-generation NANORV32 integer register file: two combinational read ports, two write ports and a per-register pending-write scoreboard.
- Includes a hardware clear sequencer that zeroes every register after reset or on request.
- Sits between decode (register selects, scoreboard set) and writeback (two result ports, e.g. ALU and load unit).

Parameters:
NUM_REGS, 32, number of architectural registers (2..2**ADDR_W).
DATA_W, 32, register width in bits.
ADDR_W, 5, register select width.
ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never busy); 0 = register 0 is ordinary.

Ports:
clk  input  1  core clock, all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
sel_porta  input  ADDR_W  read port A select.
sel_portb  input  ADDR_W  read port B select.
porta  output  DATA_W  read port A data.
portb  output  DATA_W  read port B data.
sel_rd0  input  ADDR_W  write port 0 select.
rd0  input  DATA_W  write port 0 data.
write_rd0  input  1  write port 0 enable.
sel_rd1  input  ADDR_W  write port 1 select.
rd1  input  DATA_W  write port 1 data.
write_rd1  input  1  write port 1 enable.
busy_set  input  1  mark register busy_set_sel as pending.
busy_set_sel  input  ADDR_W  register to mark pending.
busy_a  output  1  pending flag of sel_porta.
busy_b  output  1  pending flag of sel_portb.
clear_req  input  1  one-cycle pulse: restart clear sequence.
init_done  output  1  1 = register file usable.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low; clk and rst_n as named above.
- Reset (rst_n=0 at a clk edge):
  - FSM goes to INIT, clear counter = 0, init_done = 0.
  - All scoreboard bits cleared.
  - Register contents are not reset directly; the INIT sequence zeroes them.
- FSM states INIT, READY:
  - INIT: each cycle writes 0 to reg[cnt], cnt++.
  - When cnt == NUM_REGS-1 is written: go to READY; init_done = 1 from the next cycle.
  - First post-reset cycle with init_done = 1 is exactly NUM_REGS cycles after rst_n deasserts.
  - READY + clear_req: go to INIT, cnt = 0, init_done = 0 next cycle, scoreboard cleared.
  - clear_req in INIT: ignored (sequence continues).
  - rst_n low mid-INIT: restarts at cnt = 0.
- While init_done = 0:
  - porta/portb/busy_a/busy_b read 0.
  - write_rd0/1 and busy_set ignored.
- Reads: combinational from the register array.
  - Select >= NUM_REGS reads 0.
  - Select 0 with ZERO_REG=1 reads 0.
- Writes: take effect at the clk edge; value visible on reads the following cycle (see optional feature).
  - Select >= NUM_REGS, or select 0 with ZERO_REG=1: write ignored.
  - Both ports enabled, same select: port 1 wins.
- Scoreboard (one bit per register):
  - busy_set sets bit[busy_set_sel].
  - A write on either port clears bit[sel_rdN].
  - Set and clear of the same register in the same cycle: set wins (new producer).
  - Register 0 with ZERO_REG=1 never becomes busy.
  - Out-of-range busy_set_sel ignored.
  - busy_a = bit[sel_porta], busy_b = bit[sel_portb].
- No arithmetic beyond the clear counter (ADDR_W+1 bits, no wrap past NUM_REGS-1).

Optional Feature:
NANORV32_RF_BYPASS_EN:
- Defined:
  - porta/portb forward a same-cycle write to the selected register (port 1 priority over port 0, same ignore rules as writes).
  - busy_a/busy_b read 0 when that same-cycle write clears the bit, unless busy_set targets the same register that cycle.
  - Bypass is disabled while init_done = 0.
- Not defined: reads and busy flags reflect state only after the clk edge, one cycle later.

Test Plan:
- Release rst_n, NUM_REGS=32 -> init_done = 0 for 32 cycles, 1 at cycle 32; reads of x1..x31 = 0.
- READY; write_rd0 x5 = 0x12345678 -> porta (sel 5) = 0x12345678 next cycle. Write x0 = 0xFFFFFFFF with ZERO_REG=1 -> porta (sel 0) = 0.
- write_rd0 x7 = 0xA, write_rd1 x7 = 0xB, same cycle -> x7 = 0xB.
- busy_set x9 -> busy_a (sel 9) = 1. Then write_rd1 x9 = 0x55 -> busy_a = 0 next cycle. busy_set x9 together with write_rd0 x9 -> busy_a stays 1.
- x3 = 0x77; clear_req pulse -> init_done = 0 for 32 cycles, busy bits cleared, x3 = 0 after. write_rd0 during INIT -> ignored. rst_n low at cnt = 10 -> full 32-cycle restart.
- NANORV32_RF_BYPASS_EN defined: write_rd0 x4 = 0xCAFE with sel_porta = 4 -> porta = 0xCAFE in the same cycle. Macro undefined: porta = old x4 value that cycle, 0xCAFE next cycle.
